wb_port_arbiter: RTL and testbench

Shares the register file's single synchronous write port between the in-order pipeline writeback stage and one long-latency unit (load/multiply/divide) using a valid/ready return. Keeps a per-register scoreboard of outstanding long-latency destinations and drives the decode-stage hazard stall. Suppresses all writes to x0, since the register file does not protect it. Sits between the W stage and the register file write inputs `we`/`wb_addr`/`wb_data`.

---
 rtl/core_pkg.sv | 16 +
 rtl/wb_port_arbiter_if.sv | 46 ++++
 rtl/rf_scoreboard.sv | 44 ++++
 rtl/wb_port_arbiter.sv | 79 +++++++
 tb/tb_wb_port_arbiter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared core constants and the write-port grant encoding used by the
// writeback arbiter.
package core_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_PIPE,
        GRANT_LL,
        GRANT_LL_X0
    } grant_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback-side bundle of the port arbiter: pipeline W stage, long-latency
// issue/return, decode operand lookup and the register file write port.
interface wb_port_arbiter_if #(
    parameter int XLEN   = core_pkg::XLEN,
    parameter int ADDR_W = core_pkg::REG_ADDR_W
);
    logic              pipe_wb_valid;
    logic [ADDR_W-1:0] pipe_wb_addr;
    logic [XLEN-1:0]   pipe_wb_data;
    logic              pipe_stall;

    logic              ll_issue_valid;
    logic [ADDR_W-1:0] ll_issue_addr;
    logic              ll_wb_valid;
    logic              ll_wb_ready;
    logic [ADDR_W-1:0] ll_wb_addr;
    logic [XLEN-1:0]   ll_wb_data;

    logic [ADDR_W-1:0] dec_rs1_addr;
    logic [ADDR_W-1:0] dec_rs2_addr;
    logic [ADDR_W-1:0] dec_rd_addr;
    logic              hazard_stall;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_wb_addr;
    logic [XLEN-1:0]   rf_wb_data;

    modport slave (
        input  pipe_wb_valid, pipe_wb_addr, pipe_wb_data,
        input  ll_issue_valid, ll_issue_addr,
        input  ll_wb_valid, ll_wb_addr, ll_wb_data,
        input  dec_rs1_addr, dec_rs2_addr, dec_rd_addr,
        output pipe_stall, ll_wb_ready, hazard_stall,
        output rf_we, rf_wb_addr, rf_wb_data
    );

    modport master (
        output pipe_wb_valid, pipe_wb_addr, pipe_wb_data,
        output ll_issue_valid, ll_issue_addr,
        output ll_wb_valid, ll_wb_addr, ll_wb_data,
        output dec_rs1_addr, dec_rs2_addr, dec_rd_addr,
        input  pipe_stall, ll_wb_ready, hazard_stall,
        input  rf_we, rf_wb_addr, rf_wb_data
    );

endinterface

// File: rtl/rf_scoreboard.sv
// One pending bit per architectural register for outstanding long-latency
// destinations; x0 is never pending.
module rf_scoreboard #(
    parameter int ADDR_W = core_pkg::REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rs1_pending,
    output logic              rs2_pending,
    output logic              rd_pending
);
    localparam int N_ENTRIES = 1 << ADDR_W;

    logic [N_ENTRIES-1:0] pending_q;
    logic [N_ENTRIES-1:0] pending_d;

    // Set is applied after clear so a same-cycle issue to the returning
    // register keeps it pending.
    always_comb begin
        // NOTE: start from the held value so every path assigns pending_d and no latch is inferred.
        pending_d = pending_q;
        if (clr_en) pending_d[clr_addr] = 1'b0;
        if (set_en) pending_d[set_addr] = 1'b1;
        pending_d[0] = 1'b0;
    end

    // NOTE: this is a small flop array, not a RAM, so it takes the async reset like any other state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pending_q <= '0;
        else       pending_q <= pending_d;
    end

    assign rs1_pending = pending_q[rs1_addr];
    assign rs2_pending = pending_q[rs2_addr];
    assign rd_pending  = pending_q[rd_addr];

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the pipeline W stage and
// a long-latency unit, with starvation forcing and decode hazard stall.
module wb_port_arbiter #(
    parameter int XLEN       = core_pkg::XLEN,
    parameter int ADDR_W     = core_pkg::REG_ADDR_W,
    parameter int STARVE_MAX = 4
) (
    input logic              clk,
    input logic              reset,
    wb_port_arbiter_if.slave bus
);
    import core_pkg::*;

    localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    grant_e            grant;
    logic              pipe_req;
    logic              ll_req;
    logic              ll_x0;
    logic              force_ll;
    logic              ll_ready;
    logic              ll_hs;
    logic [CNT_W-1:0]  starve_cnt;
    logic [ADDR_W-1:0] wr_addr;
    logic [XLEN-1:0]   wr_data;
    logic              rs1_pending;
    logic              rs2_pending;
    logic              rd_pending;

    always_comb begin
        pipe_req = bus.pipe_wb_valid && (bus.pipe_wb_addr != '0);
        ll_req   = bus.ll_wb_valid && (bus.ll_wb_addr != '0);
        ll_x0    = bus.ll_wb_valid && (bus.ll_wb_addr == '0);
        force_ll = (starve_cnt == CNT_MAX);

        // An x0 result never uses the port, so the pipeline can still win.
        grant = GRANT_NONE;
        if (ll_x0 && !pipe_req)                  grant = GRANT_LL_X0;
        else if (pipe_req && !(force_ll && ll_req)) grant = GRANT_PIPE;
        else if (ll_req)                         grant = GRANT_LL;
    end

    assign ll_ready = !reset && (ll_x0 || (grant == GRANT_LL));
    assign ll_hs    = bus.ll_wb_valid && ll_ready;
    assign wr_addr  = (grant == GRANT_LL) ? bus.ll_wb_addr : bus.pipe_wb_addr;
    assign wr_data  = (grant == GRANT_LL) ? bus.ll_wb_data : bus.pipe_wb_data;

    assign bus.ll_wb_ready  = ll_ready;
    assign bus.rf_we        = !reset && ((grant == GRANT_PIPE) || (grant == GRANT_LL));
    assign bus.rf_wb_addr   = wr_addr;
    assign bus.rf_wb_data   = wr_data;
    assign bus.pipe_stall   = !reset && pipe_req && (grant == GRANT_LL);
    assign bus.hazard_stall = !reset && (rs1_pending || rs2_pending || rd_pending);

    // Counts cycles a valid result has waited; saturates at the force level.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (reset)                           starve_cnt <= '0;
        else if (!bus.ll_wb_valid || ll_hs)  starve_cnt <= '0;
        else if (starve_cnt != CNT_MAX)      starve_cnt <= starve_cnt + 1'b1;
    end

    rf_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .set_en      (bus.ll_issue_valid && (bus.ll_issue_addr != '0)),
        .set_addr    (bus.ll_issue_addr),
        .clr_en      (ll_hs),
        .clr_addr    (bus.ll_wb_addr),
        .rs1_addr    (bus.dec_rs1_addr),
        .rs2_addr    (bus.dec_rs2_addr),
        .rd_addr     (bus.dec_rd_addr),
        .rs1_pending (rs1_pending),
        .rs2_pending (rs2_pending),
        .rd_pending  (rd_pending)
    );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed scenarios plus random traffic
// checked against a per-cycle behavioural model.
module tb_wb_port_arbiter;
    localparam int STARVE_MAX = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wb_port_arbiter_if #(.XLEN(32), .ADDR_W(5)) bus ();

    wb_port_arbiter #(.XLEN(32), .ADDR_W(5), .STARVE_MAX(STARVE_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit rst;
        bit pv; logic [4:0] pa; logic [31:0] pd;
        bit iv; logic [4:0] ia;
        bit lv; logic [4:0] la; logic [31:0] ld;
        logic [4:0] rs1, rs2, rd;
    } stim_t;

    typedef struct {
        bit we; logic [4:0] addr; logic [31:0] data;
        bit rdy; bit stall; bit haz;
    } exp_t;

    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    bit    pend[32];
    int    ll_waited = 0;
    bit    ll_hold   = 0;
    bit    pipe_hold = 0;
    stim_t last;
    stim_t s;

    function automatic stim_t idle();
        stim_t t;
        t = '{default: 0};
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Drive one cycle of stimulus and queue what the model says must appear.
    task automatic cycle(input stim_t t);
        exp_t e;
        bit   preq, lreq, lx0, frc;
        @(posedge clk);
        #1;
        reset              = t.rst;
        bus.pipe_wb_valid  = t.pv;
        bus.pipe_wb_addr   = t.pa;
        bus.pipe_wb_data   = t.pd;
        bus.ll_issue_valid = t.iv;
        bus.ll_issue_addr  = t.ia;
        bus.ll_wb_valid    = t.lv;
        bus.ll_wb_addr     = t.la;
        bus.ll_wb_data     = t.ld;
        bus.dec_rs1_addr   = t.rs1;
        bus.dec_rs2_addr   = t.rs2;
        bus.dec_rd_addr    = t.rd;

        e = '{default: 0};
        if (t.rst) begin
            pend      = '{default: 0};
            ll_waited = 0;
            ll_hold   = 0;
            pipe_hold = 0;
        end else begin
            preq  = t.pv && (t.pa != 0);
            lreq  = t.lv && (t.la != 0);
            lx0   = t.lv && (t.la == 0);
            frc   = (ll_waited >= STARVE_MAX);
            e.haz = pend[t.rs1] | pend[t.rs2] | pend[t.rd];
            e.rdy = lx0;
            if (preq && !(frc && lreq)) begin
                e.we = 1; e.addr = t.pa; e.data = t.pd;
            end else if (lreq) begin
                e.we = 1; e.addr = t.la; e.data = t.ld; e.rdy = 1; e.stall = preq;
            end
            if (t.lv && e.rdy) pend[t.la] = 0;
            if (t.iv && (t.ia != 0)) pend[t.ia] = 1;
            ll_waited = (t.lv && !e.rdy) ? ll_waited + 1 : 0;
            ll_hold   = t.lv && !e.rdy;
            pipe_hold = e.stall;
        end
        last = t;
        exp_q.push_back(e);
    endtask

    task automatic rand_cycle();
        stim_t t;
        t = idle();
        if (ll_hold) begin
            t.lv = 1; t.la = last.la; t.ld = last.ld;
        end else begin
            t.lv = ($urandom_range(0, 9) < 4);
            t.la = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            t.ld = $urandom;
        end
        if (pipe_hold) begin
            t.pv = 1; t.pa = last.pa; t.pd = last.pd;
        end else begin
            t.pv = ($urandom_range(0, 9) < 6);
            t.pa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            t.pd = $urandom;
        end
        t.iv  = ($urandom_range(0, 9) < 3);
        t.ia  = 5'($urandom_range(0, 31));
        t.rs1 = 5'($urandom_range(0, 31));
        t.rs2 = 5'($urandom_range(0, 31));
        t.rd  = 5'($urandom_range(0, 31));
        t.rst = ($urandom_range(0, 199) == 0);
        cycle(t);
    endtask

    // Monitor: every negedge the DUT presents one cycle of outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rf_we",        32'(bus.rf_we),        32'(e.we));
                check("ll_wb_ready",  32'(bus.ll_wb_ready),  32'(e.rdy));
                check("pipe_stall",   32'(bus.pipe_stall),   32'(e.stall));
                check("hazard_stall", 32'(bus.hazard_stall), 32'(e.haz));
                if (e.we) begin
                    check("rf_wb_addr", 32'(bus.rf_wb_addr), 32'(e.addr));
                    check("rf_wb_data", bus.rf_wb_data,      e.data);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        bus.pipe_wb_valid = 0; bus.pipe_wb_addr = 0; bus.pipe_wb_data = 0;
        bus.ll_issue_valid = 0; bus.ll_issue_addr = 0;
        bus.ll_wb_valid = 0; bus.ll_wb_addr = 0; bus.ll_wb_data = 0;
        bus.dec_rs1_addr = 0; bus.dec_rs2_addr = 0; bus.dec_rd_addr = 0;

        // Reset state.
        s = idle(); s.rst = 1; cycle(s); cycle(s);

        // Pipeline only, then the same request to x0.
        s = idle(); s.pv = 1; s.pa = 5; s.pd = 32'hDEADBEEF; cycle(s);
        s.pa = 0; cycle(s);

        // Issue to 7, hazard on rs1, return with pipe idle, release.
        s = idle(); s.iv = 1; s.ia = 7; s.rs1 = 7; cycle(s);
        s = idle(); s.rs1 = 7; cycle(s);
        s.lv = 1; s.la = 7; s.ld = 32'h0000_0777; cycle(s);
        s = idle(); s.rs1 = 7; cycle(s);

        // Starvation: four pipe wins, forced LL grant, then pipe again.
        for (int i = 1; i <= 4; i++) begin
            s = idle(); s.pv = 1; s.pa = 5'(i); s.pd = 32'(i * 17);
            s.lv = 1; s.la = 9; s.ld = 32'h9999; cycle(s);
        end
        s = idle(); s.pv = 1; s.pa = 10; s.pd = 32'hA0A0; s.lv = 1; s.la = 9; s.ld = 32'h9999; cycle(s);
        s.lv = 0; cycle(s);
        s = idle(); s.pv = 1; s.pa = 11; s.pd = 32'hB1; s.lv = 1; s.la = 9; s.ld = 32'h1234; cycle(s);
        s.pv = 0; cycle(s);

        // x0 result accepted alongside a pipeline write to 3.
        s = idle(); s.pv = 1; s.pa = 3; s.pd = 32'h33; s.lv = 1; s.la = 0; s.ld = 32'hFFFF; cycle(s);

        // Same-cycle issue and return on 12 keeps it pending.
        s = idle(); s.iv = 1; s.ia = 12; cycle(s);
        s = idle(); s.iv = 1; s.ia = 12; s.lv = 1; s.la = 12; s.ld = 32'hC; s.rd = 12; cycle(s);
        s = idle(); s.rd = 12; cycle(s); cycle(s);
        s.lv = 1; s.la = 12; s.ld = 32'hCC; cycle(s);
        s = idle(); s.rd = 12; cycle(s);

        // Reset with 4 pending and the counter at 3, then restart from 0.
        s = idle(); s.iv = 1; s.ia = 4; cycle(s);
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.pv = 1; s.pa = 5'(20 + i); s.pd = 32'(i); s.rd = 4;
            s.lv = 1; s.la = 9; s.ld = 32'h4242; cycle(s);
        end
        s.rst = 1; cycle(s);
        s = idle(); s.rst = 1; cycle(s);
        for (int i = 0; i < 5; i++) begin
            s = idle(); s.pv = 1; s.pa = 5'(24 + i); s.pd = 32'(100 + i); s.rd = 4;
            s.lv = 1; s.la = 9; s.ld = 32'h5151; cycle(s);
        end
        s.lv = 0; cycle(s);

        repeat (400) rand_cycle();

        @(negedge clk);
        #1;
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
